// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the parametrised pipeline stage register.
//   stage_state_t : occupancy state of a stage (EMPTY, FULL, SKID).
//                   SKID is only reachable when PIPE_STAGE_SKID_EN is defined.
//   PIPE_CNT_W    : default width of the back-pressure cycle counter.
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } stage_state_t;

    localparam int unsigned PIPE_CNT_W = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// -----------------------------------------------------------------------------
// pipe_sat_counter
// Saturating up-counter used for stall-cycle performance debug.
//   clk   : clock, state updates on rising edge
//   reset : synchronous active-high clear
//   inc   : request to increment by one this cycle
//   count : registered count, sticks at all-ones
// -----------------------------------------------------------------------------
module pipe_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: add one unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Generic valid/ready pipeline stage register with synchronous flush and a
// saturating back-pressure counter.
//
// Build option: macro PIPE_STAGE_SKID_EN adds a second (skid) entry so that
// in_ready no longer depends combinationally on out_ready. Without it the
// stage holds a single payload and in_ready passes out_ready through.
//
// Ports:
//   clk, reset         : clock and synchronous active-high reset
//   flush              : drop everything held and incoming this cycle
//   in_valid/in_data   : upstream payload, accepted when in_ready is high
//   in_ready           : stage can take in_data this cycle
//   out_valid/out_data : registered payload to downstream
//   out_ready          : downstream accepts out_data
//   stall_cycles       : saturating count of cycles with out_valid & ~out_ready
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W      = 128,
    parameter logic [DATA_W-1:0] RESET_VALUE = {DATA_W{1'b0}},
    parameter int unsigned       CNT_W       = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  stall_cycles
);

    stage_state_t      state_q;
    stage_state_t      state_d;
    logic              valid_q;
    logic              valid_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;
`endif
    logic              in_ready_s;
    logic              in_fire_s;
    logic              out_fire_s;
    logic              stall_inc_s;

`ifdef PIPE_STAGE_SKID_EN
    // Ready only looks at local state, which cuts the out_ready -> in_ready path.
    assign in_ready_s = ~reset & ~flush & (state_q != SKID);
`else
    // Single entry: a slot frees up in the same cycle downstream takes it.
    assign in_ready_s = ~reset & (~valid_q | out_ready) & ~flush;
`endif

    assign in_fire_s  = in_valid & in_ready_s & ~flush;
    assign out_fire_s = valid_q & out_ready;
    // A flush cycle leaves the stall count untouched.
    assign stall_inc_s = valid_q & ~out_ready & ~flush;

    // Next-state and payload steering for the occupancy FSM.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_d  = skid_q;
`endif
        if (flush) begin
            state_d = EMPTY;
            main_d  = RESET_VALUE;
`ifdef PIPE_STAGE_SKID_EN
            skid_d  = RESET_VALUE;
`endif
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire_s) begin
                        state_d = FULL;
                        main_d  = in_data;
                    end else begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (in_fire_s && out_fire_s) begin
                        main_d = in_data;
                    end else if (out_fire_s) begin
                        // main_q keeps its last value while empty.
                        state_d = EMPTY;
                    end else if (in_fire_s) begin
`ifdef PIPE_STAGE_SKID_EN
                        state_d = SKID;
                        skid_d  = in_data;
`else
                        // Unreachable: in_ready is low when FULL and stalled.
                        state_d = FULL;
`endif
                    end else begin
                        state_d = FULL;
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                SKID: begin
                    if (out_fire_s) begin
                        state_d = FULL;
                        main_d  = skid_q;
                        skid_d  = RESET_VALUE;
                    end else begin
                        state_d = SKID;
                    end
                end
`endif
                default: begin
                    state_d = EMPTY;
                    main_d  = RESET_VALUE;
                end
            endcase
        end
        valid_d = (state_d != EMPTY);
    end

    // State and payload registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            main_q  <= RESET_VALUE;
`ifdef PIPE_STAGE_SKID_EN
            skid_q  <= RESET_VALUE;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            main_q  <= main_d;
`ifdef PIPE_STAGE_SKID_EN
            skid_q  <= skid_d;
`endif
        end
    end

    pipe_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc_s),
        .count (stall_cycles)
    );

    assign in_ready  = in_ready_s;
    assign out_valid = valid_q;
    assign out_data  = main_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Self-checking bench for pipe_stage_reg. A queue-based reference model tracks
// the held payloads; two DUTs share stimulus, the second with a 2-bit counter.
// Works with or without PIPE_STAGE_SKID_EN.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int unsigned     DW   = 16;
    localparam logic [DW-1:0]   RST  = 16'hA5C3;
`ifdef PIPE_STAGE_SKID_EN
    localparam int              CAP  = 2;
`else
    localparam int              CAP  = 1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [15:0]   stall_cycles;
    logic          in_ready2;
    logic          out_valid2;
    logic [DW-1:0] out_data2;
    logic [1:0]    stall2;

    int total = 0;
    int bad   = 0;

    // reference model
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_last;
    int            m_cnt;
    int            m_cnt2;

    pipe_stage_reg #(.DATA_W(DW), .RESET_VALUE(RST), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .stall_cycles(stall_cycles)
    );

    pipe_stage_reg #(.DATA_W(DW), .RESET_VALUE(RST), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready2), .out_valid(out_valid2),
        .out_data(out_data2), .out_ready(out_ready), .stall_cycles(stall2)
    );

    always #5 clk = ~clk;

    // One clock cycle: compare DUT against the model, clock, advance the model.
    task automatic step(input string tag);
        logic          e_ready;
        logic          e_valid;
        logic [DW-1:0] e_data;
        logic          in_fire;
        logic          out_fire;
        e_valid = (mq.size() > 0);
        e_data  = e_valid ? mq[0] : m_last;
        e_ready = !reset && !flush && ((mq.size() < CAP) || (CAP == 1 && out_ready));
        #1;
        total++;
        if (in_ready !== e_ready) begin
            bad++; $display("FAIL %s in_ready got=%b want=%b", tag, in_ready, e_ready);
        end
        total++;
        if (out_valid !== e_valid) begin
            bad++; $display("FAIL %s out_valid got=%b want=%b", tag, out_valid, e_valid);
        end
        total++;
        if (out_data !== e_data) begin
            bad++; $display("FAIL %s out_data got=%h want=%h", tag, out_data, e_data);
        end
        total++;
        if (stall_cycles !== 16'(m_cnt)) begin
            bad++; $display("FAIL %s stall_cycles got=%0d want=%0d", tag, stall_cycles, m_cnt);
        end
        total++;
        if (stall2 !== 2'(m_cnt2)) begin
            bad++; $display("FAIL %s stall2 got=%0d want=%0d", tag, stall2, m_cnt2);
        end
        in_fire  = in_valid && e_ready && !flush;
        out_fire = e_valid && out_ready;
        @(posedge clk);
        if (reset) begin
            mq.delete(); m_last = RST; m_cnt = 0; m_cnt2 = 0;
        end else begin
            if (e_valid && !out_ready && !flush) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (flush) begin
                mq.delete(); m_last = RST;
            end else begin
                if (out_fire) m_last = mq.pop_front();
                if (in_fire) mq.push_back(in_data);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid got=%b want=0", out_valid); end
        total++; if (out_data !== RST) begin bad++; $display("FAIL reset out_data got=%h want=%h", out_data, RST); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset in_ready got=%b want=0", in_ready); end
        total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL reset stall got=%0d want=0", stall_cycles); end
        reset = 1'b0; in_valid = 1'b0; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release in_ready got=%b want=1", in_ready); end
        mq.delete(); m_last = RST; m_cnt = 0; m_cnt2 = 0;
        @(negedge clk);
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_data = 16'(i);
            step("stream");
            total++;
            if (out_valid !== 1'b1 || out_data !== 16'(i)) begin
                bad++; $display("FAIL stream_seq got=%b/%h want=1/%h", out_valid, out_data, 16'(i));
            end
        end
        in_valid = 1'b0;
        step("stream_tail");
        step("stream_tail");
        total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL stream_stall got=%0d want=0", stall_cycles); end
    endtask

    task automatic test_backpressure();
`ifdef PIPE_STAGE_SKID_EN
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h000A; step("bp_push");
        in_data = 16'h000B; step("bp_push");
        in_valid = 1'b0; #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_skid in_ready got=%b want=0", in_ready); end
        step("bp_hold"); step("bp_hold");
        out_ready = 1'b1; #1;
        total++; if (out_data !== 16'h000A) begin bad++; $display("FAIL bp_order0 got=%h want=000a", out_data); end
        step("bp_drain");
        total++; if (out_valid !== 1'b1 || out_data !== 16'h000B) begin bad++; $display("FAIL bp_order1 got=%b/%h want=1/000b", out_valid, out_data); end
        step("bp_drain"); step("bp_drain");
`else
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h000A; step("bp_push");
        in_data = 16'h000B; #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full in_ready got=%b want=0", in_ready); end
        out_ready = 1'b1; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_comb_hi in_ready got=%b want=1", in_ready); end
        out_ready = 1'b0; #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_comb_lo in_ready got=%b want=0", in_ready); end
        in_valid = 1'b0;
        step("bp_hold");
        out_ready = 1'b1;
        step("bp_drain"); step("bp_drain");
`endif
    endtask

    task automatic test_flush();
        logic [15:0] s;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < CAP; i++) begin
            in_data = 16'(16'h000A + i); step("fl_fill");
        end
        in_valid = 1'b0; step("fl_hold");
        s = stall_cycles;
        flush = 1'b1; in_valid = 1'b1; in_data = 16'h000C;
        step("fl_pulse");
        flush = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush out_valid got=%b want=0", out_valid); end
        total++; if (out_data !== RST) begin bad++; $display("FAIL flush out_data got=%h want=%h", out_data, RST); end
        total++; if (stall_cycles !== s) begin bad++; $display("FAIL flush stall got=%0d want=%0d", stall_cycles, s); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("fl_after");
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_leak out_valid got=%b want=0", out_valid); end
        end
    endtask

    task automatic test_saturation();
        reset = 1'b1; step("sat_rst"); reset = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h00D0;
        step("sat_push");
        in_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step("sat_hold");
            total++;
            if (stall2 !== 2'((k < 3) ? k : 3)) begin
                bad++; $display("FAIL sat_seq k=%0d got=%0d want=%0d", k, stall2, (k < 3) ? k : 3);
            end
        end
        out_ready = 1'b1; step("sat_drain"); step("sat_drain");
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 99) < 2);
            flush     = ($urandom_range(0, 99) < 6);
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 60);
            in_data   = 16'($urandom);
            step("rand");
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step("rand_end"); step("rand_end"); step("rand_end");
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
